// File: rtl/nic_apb_router.sv
// nic_apb_router: registered APB 1-to-NUM_M node, one-hot select decoded from paddr[SEL_LSB +: IW].
// Build option NIC_APB_TIMEOUT_EN bounds downstream wait states to TIMEOUT ACCESS cycles.
module nic_apb_router #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int NUM_M   = 4,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 255
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [AW-1:0]       s_paddr,
  input  logic [2:0]          s_pprot,
  input  logic                s_psel,
  input  logic                s_penable,
  input  logic                s_pwrite,
  input  logic [DW-1:0]       s_pwdata,
  input  logic [DW/8-1:0]     s_pstrb,
  output logic                s_pready,
  output logic                s_pslverr,
  output logic [DW-1:0]       s_prdata,
  output logic [AW-1:0]       m_paddr,
  output logic [2:0]          m_pprot,
  output logic [NUM_M-1:0]    m_psel,
  output logic                m_penable,
  output logic                m_pwrite,
  output logic [DW-1:0]       m_pwdata,
  output logic [DW/8-1:0]     m_pstrb,
  input  logic [NUM_M-1:0]    m_pready,
  input  logic [NUM_M-1:0]    m_pslverr,
  input  logic [NUM_M*DW-1:0] m_prdata
);
  // state  | meaning
  // IDLE   | waiting for an upstream setup phase
  // SETUP  | downstream psel asserted, penable low
  // ACCESS | downstream penable high, waiting for the selected pready
  // RESP   | upstream pready with captured pslverr/prdata
  // ERR    | upstream pready with pslverr, no downstream access
  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RESP, ERR} state_t;

  state_t             state_q, state_n;
  logic [IW-1:0]      idx_q, idx_n, idx_in;
  logic [AW-1:0]      paddr_n;
  logic [2:0]         pprot_n;
  logic               pwrite_n;
  logic [DW-1:0]      pwdata_n;
  logic [DW/8-1:0]    pstrb_n;
  logic [NUM_M-1:0]   psel_n;
  logic               penable_n;
  logic               pready_n;
  logic               pslverr_n;
  logic [DW-1:0]      prdata_n;

`ifdef NIC_APB_TIMEOUT_EN
  localparam int CW_RAW = $clog2(TIMEOUT + 1);
  localparam int CW     = (CW_RAW < 8) ? 8 : ((CW_RAW > 16) ? 16 : CW_RAW);
  logic [CW-1:0]      cnt_q, cnt_n;
`endif

  assign idx_in = s_paddr[SEL_LSB +: IW];

  always_comb begin
    state_n   = state_q;
    idx_n     = idx_q;
    paddr_n   = m_paddr;
    pprot_n   = m_pprot;
    pwrite_n  = m_pwrite;
    pwdata_n  = m_pwdata;
    pstrb_n   = m_pstrb;
    psel_n    = m_psel;
    penable_n = m_penable;
    pready_n  = 1'b0;
    pslverr_n = 1'b0;
    prdata_n  = '0;
`ifdef NIC_APB_TIMEOUT_EN
    cnt_n     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (s_psel && !s_penable) begin
          if (int'(idx_in) < NUM_M) begin
            idx_n    = idx_in;
            paddr_n  = s_paddr;
            pprot_n  = s_pprot;
            pwrite_n = s_pwrite;
            pwdata_n = s_pwdata;
            pstrb_n  = s_pstrb;
            psel_n   = NUM_M'(1) << idx_in;
            state_n  = SETUP;
          end else begin
            // unmapped: answer immediately, leave the downstream buses untouched
            pready_n  = 1'b1;
            pslverr_n = 1'b1;
            state_n   = ERR;
          end
        end
      end
      SETUP: begin
        penable_n = 1'b1;
        state_n   = ACCESS;
`ifdef NIC_APB_TIMEOUT_EN
        cnt_n     = '0;
`endif
      end
      ACCESS: begin
        if (m_pready[idx_q]) begin
          psel_n    = '0;
          penable_n = 1'b0;
          pready_n  = 1'b1;
          pslverr_n = m_pslverr[idx_q];
          prdata_n  = m_pwrite ? '0 : m_prdata[idx_q*DW +: DW];
          state_n   = RESP;
        end
`ifdef NIC_APB_TIMEOUT_EN
        else if (cnt_q >= CW'(TIMEOUT - 1)) begin
          psel_n    = '0;
          penable_n = 1'b0;
          pready_n  = 1'b1;
          pslverr_n = 1'b1;
          state_n   = ERR;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
`endif
      end
      RESP:    state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      m_paddr   <= '0;
      m_pprot   <= '0;
      m_pwrite  <= 1'b0;
      m_pwdata  <= '0;
      m_pstrb   <= '0;
      m_psel    <= '0;
      m_penable <= 1'b0;
      s_pready  <= 1'b0;
      s_pslverr <= 1'b0;
      s_prdata  <= '0;
`ifdef NIC_APB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_n;
      idx_q     <= idx_n;
      m_paddr   <= paddr_n;
      m_pprot   <= pprot_n;
      m_pwrite  <= pwrite_n;
      m_pwdata  <= pwdata_n;
      m_pstrb   <= pstrb_n;
      m_psel    <= psel_n;
      m_penable <= penable_n;
      s_pready  <= pready_n;
      s_pslverr <= pslverr_n;
      s_prdata  <= prdata_n;
`ifdef NIC_APB_TIMEOUT_EN
      cnt_q     <= cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_nic_apb_router.sv
// tb_nic_apb_router: table-driven and randomized transfers against a behavioural model.
// NUM_M=5 so that port indices 5..7 are unmapped; TIMEOUT=8 for builds with NIC_APB_TIMEOUT_EN.
module tb_nic_apb_router;
  localparam int NM = 5;
  localparam int TO = 8;

  logic             clock = 1'b0;
  logic             resetn;
  logic [31:0]      s_paddr;
  logic [2:0]       s_pprot;
  logic             s_psel, s_penable, s_pwrite;
  logic [31:0]      s_pwdata;
  logic [3:0]       s_pstrb;
  logic             s_pready, s_pslverr;
  logic [31:0]      s_prdata;
  logic [31:0]      m_paddr;
  logic [2:0]       m_pprot;
  logic [NM-1:0]    m_psel;
  logic             m_penable, m_pwrite;
  logic [31:0]      m_pwdata;
  logic [3:0]       m_pstrb;
  logic [NM-1:0]    m_pready, m_pslverr;
  logic [NM*32-1:0] m_prdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  nic_apb_router #(.AW(32), .DW(32), .NUM_M(NM), .SEL_LSB(12), .TIMEOUT(TO)) dut (
    .clock(clock), .resetn(resetn),
    .s_paddr(s_paddr), .s_pprot(s_pprot), .s_psel(s_psel), .s_penable(s_penable),
    .s_pwrite(s_pwrite), .s_pwdata(s_pwdata), .s_pstrb(s_pstrb),
    .s_pready(s_pready), .s_pslverr(s_pslverr), .s_prdata(s_prdata),
    .m_paddr(m_paddr), .m_pprot(m_pprot), .m_psel(m_psel), .m_penable(m_penable),
    .m_pwrite(m_pwrite), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb),
    .m_pready(m_pready), .m_pslverr(m_pslverr), .m_prdata(m_prdata)
  );

  typedef struct {
    logic [31:0]   addr;
    logic [2:0]    prot;
    logic          write;
    logic [31:0]   wdata;
    logic [3:0]    strb;
    int            waits;
    logic [31:0]   rdata;
    logic          slverr;
    logic          drop;
    int            exp_lat;
    logic          exp_slverr;
    logic [31:0]   exp_prdata;
    logic [NM-1:0] exp_psel;
    int            exp_pen;
    int            exp_psel_cyc;
  } vec_t;

  typedef struct {
    int            lat;
    logic          slverr;
    logic [31:0]   prdata;
    logic [NM-1:0] psel_or;
    int            psel_cyc;
    int            pen_cyc;
    logic [31:0]   addr, wdata;
    logic [3:0]    strb;
    logic          write;
    logic [2:0]    prot;
    logic          after_rdy;
    logic [31:0]   after_prdata;
    logic          timed_out;
  } res_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] addr, input logic w, input logic [31:0] wd,
                              input logic [3:0] st, input int waits, input logic [31:0] rd,
                              input logic se, input logic drop, input int lat, input logic eslv,
                              input logic [31:0] eprd, input logic [NM-1:0] epsel,
                              input int epen, input int ecyc);
    vec_t v;
    v.addr = addr; v.prot = addr[6:4]; v.write = w; v.wdata = wd; v.strb = st;
    v.waits = waits; v.rdata = rd; v.slverr = se; v.drop = drop;
    v.exp_lat = lat; v.exp_slverr = eslv; v.exp_prdata = eprd; v.exp_psel = epsel;
    v.exp_pen = epen; v.exp_psel_cyc = ecyc;
    return v;
  endfunction

  // Expected outcome of a transfer from the address map and the peripheral's behaviour.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int idx = int'((v.addr >> 12) & 32'h7);
    bit to_en = 1'b0;
`ifdef NIC_APB_TIMEOUT_EN
    to_en = 1'b1;
`endif
    if (idx >= NM) begin
      r.exp_lat = 0; r.exp_slverr = 1'b1; r.exp_prdata = '0;
      r.exp_psel = '0; r.exp_pen = 0; r.exp_psel_cyc = 0;
    end else if (to_en && v.waits >= TO) begin
      r.exp_lat = TO + 1; r.exp_slverr = 1'b1; r.exp_prdata = '0;
      r.exp_psel = NM'(1 << idx); r.exp_pen = TO; r.exp_psel_cyc = TO + 1;
    end else begin
      r.exp_lat = v.waits + 2; r.exp_slverr = v.slverr;
      r.exp_prdata = v.write ? 32'h0 : v.rdata;
      r.exp_psel = NM'(1 << idx); r.exp_pen = v.waits + 1; r.exp_psel_cyc = v.waits + 2;
    end
    return r;
  endfunction

  task automatic noise();
    m_pready  = NM'($urandom);
    m_pslverr = NM'($urandom);
    for (int i = 0; i < NM; i++) m_prdata[i*32 +: 32] = $urandom;
  endtask

  // Runs one upstream transfer; called and returns #1 after a rising edge.
  task automatic xfer(input vec_t v, output res_t r);
    int acc = 0;
    int cyc = 0;
    bit done = 0;
    bit first = 1;
    r = '{lat: -1, slverr: 1'b0, prdata: '0, psel_or: '0, psel_cyc: 0, pen_cyc: 0,
          addr: '0, wdata: '0, strb: '0, write: 1'b0, prot: '0, after_rdy: 1'b0,
          after_prdata: '0, timed_out: 1'b0};
    s_paddr = v.addr; s_pprot = v.prot; s_pwrite = v.write; s_pwdata = v.wdata;
    s_pstrb = v.strb; s_psel = 1'b1; s_penable = 1'b0;
    noise();
    @(posedge clock); #1;
    if (v.drop) begin s_psel = 1'b0; s_penable = 1'b0; end
    else s_penable = 1'b1;
    while (!done && cyc < 200) begin
      noise();
      if (m_penable) begin
        for (int i = 0; i < NM; i++) begin
          if (m_psel[i]) begin
            m_pready[i] = (acc == v.waits);
            if (acc == v.waits) begin
              m_pslverr[i] = v.slverr;
              m_prdata[i*32 +: 32] = v.rdata;
            end
          end
        end
        acc++;
      end
      @(negedge clock);
      if (s_pready) begin
        done = 1; r.lat = cyc; r.slverr = s_pslverr; r.prdata = s_prdata;
      end
      r.psel_or |= m_psel;
      if (m_psel != '0) r.psel_cyc++;
      if (m_penable) r.pen_cyc++;
      if (m_psel != '0 && first) begin
        first = 0; r.addr = m_paddr; r.wdata = m_pwdata; r.strb = m_pstrb;
        r.write = m_pwrite; r.prot = m_pprot;
      end
      @(posedge clock); #1;
      cyc++;
    end
    r.timed_out = !done;
    s_psel = 1'b0; s_penable = 1'b0;
    noise();
    @(negedge clock);
    r.after_rdy = s_pready; r.after_prdata = s_prdata;
    @(posedge clock); #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    res_t r;
    xfer(v, r);
    chk({tag, ".no_response"}, r.timed_out, 1'b0);
    chk({tag, ".latency"}, r.lat, v.exp_lat);
    chk({tag, ".pslverr"}, r.slverr, v.exp_slverr);
    chk({tag, ".prdata"}, r.prdata, v.exp_prdata);
    chk({tag, ".m_psel"}, r.psel_or, v.exp_psel);
    chk({tag, ".psel_cycles"}, r.psel_cyc, v.exp_psel_cyc);
    chk({tag, ".penable_cycles"}, r.pen_cyc, v.exp_pen);
    chk({tag, ".pready_after"}, r.after_rdy, 1'b0);
    chk({tag, ".prdata_after"}, r.after_prdata, 32'h0);
    if (v.exp_psel != '0) begin
      chk({tag, ".m_paddr"}, r.addr, v.addr);
      chk({tag, ".m_pwdata"}, r.wdata, v.wdata);
      chk({tag, ".m_pstrb"}, r.strb, v.strb);
      chk({tag, ".m_pwrite"}, r.write, v.write);
      chk({tag, ".m_pprot"}, r.prot, v.prot);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".s_pready"}, s_pready, 1'b0);
    chk({tag, ".s_pslverr"}, s_pslverr, 1'b0);
    chk({tag, ".s_prdata"}, s_prdata, 32'h0);
    chk({tag, ".m_psel"}, m_psel, '0);
    chk({tag, ".m_penable"}, m_penable, 1'b0);
    chk({tag, ".m_paddr"}, m_paddr, 32'h0);
    chk({tag, ".m_pwdata"}, m_pwdata, 32'h0);
    chk({tag, ".m_pstrb"}, m_pstrb, 4'h0);
    chk({tag, ".m_pwrite"}, m_pwrite, 1'b0);
    chk({tag, ".m_pprot"}, m_pprot, 3'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    vec_t v;
    tbl[0] = mk(32'h0000_2004, 1, 32'hDEADBEEF, 4'hF, 0, 32'hAAAA5555, 0, 0, 2, 0, 32'h0, 5'b00100, 1, 2);
    tbl[1] = mk(32'h0000_1010, 0, 32'h0, 4'h0, 3, 32'h12345678, 0, 0, 5, 0, 32'h12345678, 5'b00010, 4, 5);
    tbl[2] = mk(32'h0000_5000, 0, 32'h0, 4'h0, 0, 32'h11111111, 0, 0, 0, 1, 32'h0, 5'b00000, 0, 0);
    tbl[3] = mk(32'h0000_0008, 1, 32'h00000011, 4'h3, 1, 32'h22222222, 1, 0, 3, 1, 32'h0, 5'b00001, 2, 3);
    tbl[4] = mk(32'h0000_4FFC, 0, 32'h0, 4'h0, 0, 32'hCAFEF00D, 0, 0, 2, 0, 32'hCAFEF00D, 5'b10000, 1, 2);
    tbl[5] = mk(32'h0000_7ABC, 1, 32'h33333333, 4'hF, 0, 32'h0, 0, 0, 0, 1, 32'h0, 5'b00000, 0, 0);
    tbl[6] = mk(32'h0000_3000, 0, 32'h0, 4'h0, 2, 32'h0BADC0DE, 1, 0, 4, 1, 32'h0BADC0DE, 5'b01000, 3, 4);
    tbl[7] = mk(32'h0000_4000, 1, 32'h55AA55AA, 4'h5, 2, 32'h44444444, 0, 1, 4, 0, 32'h0, 5'b10000, 3, 4);

    resetn = 1'b0; s_paddr = '0; s_pprot = '0; s_psel = 1'b0; s_penable = 1'b0;
    s_pwrite = 1'b0; s_pwdata = '0; s_pstrb = '0;
    noise();
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_all_zero("reset");
    @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // reset while the downstream access is stalled
    s_paddr = 32'h0000_1000; s_pprot = 3'h5; s_pwrite = 1'b1; s_pwdata = 32'h77777777;
    s_pstrb = 4'hF; s_psel = 1'b1; s_penable = 1'b0; m_pready = '0;
    @(posedge clock); #1; s_penable = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("rst_mid.in_access", m_penable, 1'b1);
    resetn = 1'b0; s_psel = 1'b0; s_penable = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    chk_all_zero("rst_mid");
    @(posedge clock); #1;
    resetn = 1'b1;
    @(negedge clock);
    chk("rst_mid.no_resp", s_pready, 1'b0);
    chk("rst_mid.no_psel", m_psel, '0);
    @(posedge clock); #1;
    run_vec(mk(32'h0000_3008, 1, 32'h0F0F0F0F, 4'hA, 1, 32'h0, 0, 0, 3, 0, 32'h0, 5'b01000, 2, 3),
            "post_rst_p3");

`ifdef NIC_APB_TIMEOUT_EN
    run_vec(mk(32'h0000_1000, 0, 32'h0, 4'h0, 1000, 32'h99999999, 0, 0, 9, 1, 32'h0, 5'b00010, 8, 9),
            "timeout");
    run_vec(mk(32'h0000_1000, 0, 32'h0, 4'h0, 7, 32'h600D600D, 0, 0, 9, 0, 32'h600D600D, 5'b00010, 8, 9),
            "ready_at_limit");
`endif

    for (int i = 0; i < 40; i++) begin
      v.addr = $urandom;
      v.addr[14:12] = 3'($urandom_range(0, 7));
      v.prot = 3'($urandom);
      v.write = 1'($urandom);
      v.wdata = $urandom;
      v.strb = 4'($urandom);
`ifdef NIC_APB_TIMEOUT_EN
      v.waits = $urandom_range(0, 11);
`else
      v.waits = $urandom_range(0, 5);
`endif
      v.rdata = $urandom;
      v.slverr = 1'($urandom);
      v.drop = 1'b0;
      run_vec(model(v), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
